fpu_div_sched: RTL and testbench

Round-robin scheduler that shares one Goldschmidt floating-point divider (goldschmidtVersion2 port set: dividend, divisor, start, busy, ready, quotient, rem) between NREQ requesters. It accepts one IEEE-754 single-precision divide request at a time, sequences the divider's start/ready handshake, and returns the result with the winning requester's ID on a single response channel. Divide-by-zero is bypassed without using the divider, and a timeout reports a stuck divider. The block sits between the FPU issue logic and the divider instance.

---
 rtl/fpu_div_sched.sv | 146 ++++++++++++++
 tb/tb_fpu_div_sched.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fpu_div_sched.sv
// Round-robin front end that time-shares one Goldschmidt divider between NREQ issue ports.
// One divide is in flight at a time. A zero divisor is answered locally, and a stuck divider is answered with an error after TIMEOUT cycles.
module fpu_div_sched #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 clrn,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [32*NREQ-1:0]   req_dividend,
  input  logic [32*NREQ-1:0]   req_divisor,
  output logic [31:0]          div_dividend,
  output logic [31:0]          div_divisor,
  output logic                 div_start,
  input  logic                 div_busy,
  input  logic                 div_ready,
  input  logic [31:0]          div_quotient,
  input  logic [31:0]          div_rem,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [1:0]           rsp_id,
  output logic [31:0]          rsp_quotient,
  output logic [31:0]          rsp_rem,
  output logic                 rsp_err
);
  typedef enum logic [2:0] {IDLE, START, DRAIN, RUN, RESP} state_t;

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] quo;
    logic [31:0] rem;
    logic        err;
  } rsp_t;

  localparam logic [1:0]  LAST  = 2'(NREQ - 1);
  localparam logic [15:0] TLAST = 16'(TIMEOUT - 1);

  state_t            state;
  rsp_t              rsp_r;
  logic [1:0]        rr_ptr;
  logic [15:0]       tcnt;
  logic [NREQ-1:0]   gnt;
  logic [1:0]        gnt_id;
  logic              found;
  logic [31:0]       sel_a, sel_b;
  logic              unused_busy;

  assign unused_busy = div_busy;

  // First valid requester at or after rr_ptr, wrapping.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    for (int k = 0; k < NREQ; k++)
      for (int i = 0; i < NREQ; i++)
        if (!found && req_valid[i] && i == (int'(rr_ptr) + k) % NREQ) begin
          found  = 1'b1;
          gnt[i] = 1'b1;
          gnt_id = 2'(i);
        end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++)
      if (gnt[i]) begin
        sel_a = req_dividend[32*i +: 32];
        sel_b = req_divisor[32*i +: 32];
      end
  end

  assign req_ready    = (state == IDLE && !clrn) ? gnt : '0;
  assign rsp_id       = rsp_r.id;
  assign rsp_quotient = rsp_r.quo;
  assign rsp_rem      = rsp_r.rem;
  assign rsp_err      = rsp_r.err;

  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      tcnt         <= '0;
      div_start    <= 1'b0;
      div_dividend <= '0;
      div_divisor  <= '0;
      rsp_valid    <= 1'b0;
      rsp_r        <= '0;
    end else begin
      div_start <= 1'b0;
      case (state)
        IDLE: if (found) begin
          div_dividend <= sel_a;
          div_divisor  <= sel_b;
          rsp_r.id     <= gnt_id;
          rr_ptr       <= (gnt_id == LAST) ? 2'd0 : gnt_id + 2'd1;
          if (sel_b[30:0] == 31'd0) begin
            rsp_r.quo <= {sel_a[31] ^ sel_b[31], 8'hFF, 23'h0};
            rsp_r.rem <= '0;
            rsp_r.err <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            tcnt      <= '0;
            div_start <= 1'b1;
            state     <= START;
          end
        end
        START: state <= DRAIN;
        // A ready level left high by the previous divide must fall before the result can be trusted.
        DRAIN: if (tcnt == TLAST) begin
          rsp_r.quo <= 32'h7FC00000;
          rsp_r.rem <= '0;
          rsp_r.err <= 1'b1;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end else begin
          tcnt <= tcnt + 16'd1;
          if (!div_ready) state <= RUN;
        end
        RUN: if (div_ready) begin
          rsp_r.quo <= div_quotient;
          rsp_r.rem <= div_rem;
          rsp_r.err <= 1'b0;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end else if (tcnt == TLAST) begin
          rsp_r.quo <= 32'h7FC00000;
          rsp_r.rem <= '0;
          rsp_r.err <= 1'b1;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end else begin
          tcnt <= tcnt + 16'd1;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fpu_div_sched.sv
// Directed bench for fpu_div_sched with a level-ready divider model that leaves ready high between ops.
module tb_fpu_div_sched;
  logic        clk = 1'b0;
  logic        clrn;
  logic [1:0]  req_valid, req_ready;
  logic [63:0] req_dividend, req_divisor;
  logic [31:0] div_dividend, div_divisor;
  logic        div_start, div_busy;
  logic        div_ready = 1'b0;
  logic [31:0] div_quotient = 32'h0;
  logic [31:0] div_rem = 32'h0;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [1:0]  rsp_id;
  logic [31:0] rsp_quotient, rsp_rem;

  fpu_div_sched #(.NREQ(2), .TIMEOUT(10)) dut (
    .clk(clk), .clrn(clrn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_start(div_start), .div_busy(div_busy), .div_ready(div_ready),
    .div_quotient(div_quotient), .div_rem(div_rem),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_quotient(rsp_quotient), .rsp_rem(rsp_rem), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // Divider model: ready stays high one cycle past start, drops, then rises with the new result.
  logic [31:0] mdl_q = 32'h0;
  logic [31:0] m_q = 32'h0;
  int          m_cnt = 0;
  bit          hang = 1'b0;
  assign div_busy = (m_cnt > 0);

  always @(posedge clk) begin
    if (div_start) begin
      m_cnt <= 6;
      m_q   <= mdl_q;
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 6) div_ready <= 1'b0;
      if (m_cnt == 1 && !hang) begin
        div_ready    <= 1'b1;
        div_quotient <= m_q;
        div_rem      <= 32'h0;
      end
    end
  end

  int n_chk = 0;
  int n_fail = 0;
  int cyc, st, n, viol, bad;
  int ids[4];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic [1:0] vld, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] q, input logic [1:0] exp_rdy, input string tag);
    req_valid    = vld;
    req_dividend = {a, a};
    req_divisor  = {b, b};
    mdl_q        = q;
    #1 chk(tag, req_ready, exp_rdy);
    @(negedge clk);
    req_valid = 2'b00;
  endtask

  task automatic wait_rsp(output int c, output int starts);
    c = 0;
    starts = int'(div_start);
    while (!rsp_valid && c < 100) begin
      @(negedge clk);
      c++;
      if (div_start) starts++;
    end
    if (!rsp_valid) chk("rsp_wait", rsp_valid, 1);
  endtask

  task automatic rsp_pulse(input string tag);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk(tag, rsp_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    clrn = 1'b1; req_valid = 2'b11; req_dividend = '0; req_divisor = '0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_div_start", div_start, 0);
    chk("rst_div_dividend", div_dividend, 0);
    chk("rst_div_divisor", div_divisor, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp", {rsp_id, rsp_quotient, rsp_rem, rsp_err}, 0);
    req_valid = 2'b00;
    clrn = 1'b0;

    // 2.0 / 0.5 = 4.0 from requester 0
    issue(2'b01, 32'h40000000, 32'h3F000000, 32'h40800000, 2'b01, "op1_gnt");
    chk("op1_start_t1", div_start, 1);
    wait_rsp(cyc, st);
    chk("op1_starts", st, 1);
    chk("op1_q", rsp_quotient, 32'h40800000);
    chk("op1_id", rsp_id, 0);
    chk("op1_err", rsp_err, 0);
    rsp_pulse("op1_drop");

    // -2.0 / -0.0 -> +inf via bypass, requester 1 (rr_ptr = 1)
    issue(2'b10, 32'hC0000000, 32'h80000000, 32'h0, 2'b10, "dz_gnt");
    chk("dz_valid", rsp_valid, 1);
    chk("dz_q", rsp_quotient, 32'h7F800000);
    chk("dz_rem_err", {rsp_rem, rsp_err}, 0);
    chk("dz_id", rsp_id, 1);
    chk("dz_start", div_start, 0);
    rsp_pulse("dz_drop");

    // fairness: both requesters held, consumer always ready
    req_valid = 2'b11; req_dividend = {32'h40400000, 32'h40000000};
    req_divisor = {32'h3F800000, 32'h3F800000}; mdl_q = 32'h12345678;
    rsp_ready = 1'b1; n = 0; viol = 0; cyc = 0;
    for (int i = 0; i < 4; i++) ids[i] = 9;
    while (n < 4 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (req_ready == 2'b11 || (req_ready != 2'b00 && (rsp_valid || div_start))) viol++;
      if (rsp_valid && rsp_ready) begin ids[n] = int'(rsp_id); n++; end
    end
    req_valid = 2'b00;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("fair_count", n, 4);
    chk("fair_id0", ids[0], 0);
    chk("fair_id1", ids[1], 1);
    chk("fair_id2", ids[2], 0);
    chk("fair_id3", ids[3], 1);
    chk("fair_ready_outside_idle", viol, 0);

    // stale ready: previous 12345678 still presented, 3.0 / 1.5 = 2.0 expected
    issue(2'b10, 32'h40400000, 32'h3FC00000, 32'h40000000, 2'b10, "stale_gnt");
    wait_rsp(cyc, st);
    chk("stale_q", rsp_quotient, 32'h40000000);
    chk("stale_id", rsp_id, 1);
    chk("stale_err", rsp_err, 0);
    rsp_pulse("stale_drop");

    // timeout: divider never raises ready; lone requester 1 granted again
    hang = 1'b1;
    issue(2'b10, 32'h3F800000, 32'h40000000, 32'h0, 2'b10, "tmo_gnt");
    chk("tmo_start", div_start, 1);
    wait_rsp(cyc, st);
    chk("tmo_latency", cyc, 11);
    chk("tmo_err", rsp_err, 1);
    chk("tmo_q", rsp_quotient, 32'h7FC00000);
    chk("tmo_rem", rsp_rem, 0);
    chk("tmo_id", rsp_id, 1);

    // backpressure: response held, no accept while requester 0 waits
    req_valid = 2'b01; req_dividend = {32'h0, 32'h40A00000}; req_divisor = {32'h0, 32'h40000000};
    hang = 1'b0; mdl_q = 32'h40200000; bad = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (!(rsp_valid && rsp_err && rsp_quotient == 32'h7FC00000 && rsp_id == 2'd1 &&
            rsp_rem == 32'h0 && req_ready == 2'b00 && !div_start)) bad++;
    end
    chk("bp_stable", bad, 0);
    rsp_pulse("bp_drop");
    chk("bp_next_gnt", req_ready, 2'b01);
    @(negedge clk);
    req_valid = 2'b00;
    chk("rr_start", div_start, 1);
    repeat (4) @(negedge clk);

    // asynchronous reset while RUN is waiting
    #1 clrn = 1'b1;
    #1;
    chk("arst_rsp_valid", rsp_valid, 0);
    chk("arst_rsp", {rsp_id, rsp_quotient, rsp_rem, rsp_err}, 0);
    chk("arst_div_ops", {div_dividend, div_divisor}, 0);
    chk("arst_div_start", div_start, 0);
    chk("arst_req_ready", req_ready, 0);
    @(negedge clk);
    clrn = 1'b0;
    issue(2'b11, 32'h40A00000, 32'h40000000, 32'h40200000, 2'b01, "post_rst_gnt");
    wait_rsp(cyc, st);
    chk("post_rst_q", rsp_quotient, 32'h40200000);
    chk("post_rst_id", rsp_id, 0);
    rsp_pulse("post_rst_drop");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
